serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Bit-serial multi-bit subtractor sequencer: computes diff = a - b (unsigned, mod 2^WIDTH) and a final borrow.
- Reuses one full-subtractor bit cell (D = x^y^bin; Bout = (~x&y) | (~(x^y)&bin)) over WIDTH clock cycles.
- The FSM, operand shift registers, borrow flip-flop and bit counter are all in this block.
- Sits between a requester (start/done handshake) and the team's subtractor cells; trades latency for area versus a ripple chain.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse/level; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle completion strobe.
- diff  output  WIDTH  registered result; held until the next completion.
- borrow  output  1  registered final borrow (1 iff a < b); held with diff.

Behaviour:
- Reset (rst_n low, async, any state): state = IDLE, busy = 0, done = 0, diff = 0, borrow = 0; shift regs, borrow FF and counter cleared.
- Reset mid-operation aborts the subtraction; no done is produced.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start = 1 at an edge: load a into sa and b into sb, clear bin FF, clear the internal result shift reg, counter = 0, go to RUN.
  - start = 0: stay in IDLE.
- RUN, each edge:
  - d = sa[0]^sb[0]^bin; bout per the cell equation.
  - sa and sb shift right by 1; d enters the result shift reg at the MSB (shift right); bin <= bout; counter++.
  - When counter == WIDTH-1 at the edge (last bit processed): load diff from the completed result, load borrow from bout, go to DONE.
- DONE: done = 1 for exactly one cycle. Next edge returns to IDLE unconditionally.
- Latency:
  - start accepted at edge 0; RUN spans edges 1..WIDTH.
  - done is high in the cycle following edge WIDTH; diff/borrow are valid in that same cycle.
  - Next start is accepted at edge WIDTH+2 at the earliest. Throughput is one op per WIDTH+2 cycles.
- start while busy (RUN or DONE): ignored, with no effect on the operation in flight. A level held high restarts only once IDLE is re-entered.
- a/b changes after the accepted edge: no effect (operands captured).
- diff/borrow change only on a DONE entry or reset; never mid-RUN.
- Arithmetic: diff = (a - b) mod 2^WIDTH, LSB processed first. borrow = 1 iff a < b unsigned. No signed interpretation.
- WIDTH = 1: RUN lasts one edge; done is high in the cycle after edge 1.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, 1-cycle start at edge 0 -> busy high from edge 0; done high only in the cycle after edge 8; diff=0x37, borrow=0; outputs held after done drops.
- a=0x10, b=0x20 -> diff=0xF0, borrow=1. Also a=0x00, b=0x01 -> diff=0xFF, borrow=1. Also a=0xFF, b=0xFF -> diff=0x00, borrow=0.
- start held high continuously with a=0x05, b=0x03 -> ops complete back-to-back every 10 cycles, diff=0x02 each time. Changing a/b during RUN does not alter the in-flight result.
- Sequence:
  - Run a=0x80, b=0x01 (diff=0x7F).
  - Assert rst_n low for 1 ns at edge 4 of a second op (a=0x01, b=0x02), asynchronously between edges -> immediately busy=0, diff=0, borrow=0, no done pulse.
  - A subsequent a=0x09, b=0x04 -> diff=0x05.
- Exhaustive compare with WIDTH=4: all 256 (a,b) pairs -> diff and borrow match the reference model (a-b)&0xF and (a<b). done pulses exactly once per op.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor sequencer: computes diff = a - b (mod 2^WIDTH) and the final borrow
// by running one full-subtractor bit cell over WIDTH cycles, LSB first.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bin_q, bin_d, borrow_q, borrow_d, busy_q, busy_d, done_q, done_d;
    logic             d_bit, bout, last_bit;

    // Full-subtractor bit cell on the current operand LSBs
    assign d_bit    = sa_q[0] ^ sb_q[0] ^ bin_q;
    assign bout     = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bin_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d  = a;
                    sb_d  = b;
                    res_d = '0;
                    cnt_d = '0;
                    bin_d = 1'b0;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
                bin_d = bout;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    diff_d   = res_d;
                    borrow_d = bout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed table, random ops against an arithmetic
// model, back-to-back starts, async abort, and an exhaustive 4-bit sweep.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start4;
    logic [7:0] a8, b8, diff8;
    logic [3:0] a4, b4, diff4;
    logic       busy8, done8, borrow8, busy4, done4, borrow4;

    int nchk  = 0;
    int nfail = 0;
    int done4_cnt = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_borrow;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    always @(posedge clk) begin
        if (done4) done4_cnt <= done4_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain modular arithmetic and unsigned compare
    function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [7:0] b);
        int unsigned mask;
        mask = (1 << w) - 1;
        return {1'(a < b), 8'((int'(a) - int'(b)) & mask)};
    endfunction

    task automatic run_op(input bit w4, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_d, input logic exp_b, input string tag);
        int  lat;
        bit  seen;
        int  w;
        w = w4 ? 4 : 8;
        @(negedge clk);
        if (w4) begin start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; end
        else    begin start8 = 1'b1; a8 = a;      b8 = b;      end
        @(posedge clk); #1;
        start4 = 1'b0;
        start8 = 1'b0;
        // operands were captured; scrambling the inputs must not matter
        a4 = 4'($urandom); b4 = 4'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom);
        check({tag, " busy_after_start"}, w4 ? busy4 : busy8, 1);
        lat  = 0;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (w4 ? done4 : done8) begin
                lat  = k;
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            check({tag, " done_timeout"}, 0, 1);
        end else begin
            check({tag, " latency"}, lat, w);
            check({tag, " diff"}, w4 ? {4'b0, diff4} : diff8, exp_d);
            check({tag, " borrow"}, w4 ? borrow4 : borrow8, exp_b);
            check({tag, " busy_in_done"}, w4 ? busy4 : busy8, 1);
            @(posedge clk); #1;
            check({tag, " done_single"}, w4 ? done4 : done8, 0);
            check({tag, " busy_idle"}, w4 ? busy4 : busy8, 0);
            check({tag, " diff_held"}, w4 ? {4'b0, diff4} : diff8, exp_d);
            check({tag, " borrow_held"}, w4 ? borrow4 : borrow8, exp_b);
        end
    endtask

    initial begin
        logic [8:0] m;
        time        t_prev;
        int         ndone;
        bit         seen;

        vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};

        rst_n = 1'b0; start8 = 0; start4 = 0;
        a8 = 0; b8 = 0; a4 = 0; b4 = 0;
        #22;
        check("reset busy", busy8, 0);
        check("reset done", done8, 0);
        check("reset diff", diff8, 0);
        check("reset borrow", borrow8, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow, "vec");

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            m  = model(8, ra, rb);
            run_op(1'b0, ra, rb, m[7:0], m[8], "rand");
        end

        // start held high: ops back-to-back every WIDTH+2 cycles
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h03;
        t_prev = 0;
        for (int op = 0; op < 3; op++) begin
            @(posedge clk); #1;
            check("b2b busy", busy8, 1);
            a8 = 8'($urandom); b8 = 8'($urandom);
            seen = 0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                if (done8) begin seen = 1; break; end
            end
            check("b2b done_seen", seen, 1);
            check("b2b diff", diff8, 8'h02);
            check("b2b borrow", borrow8, 0);
            if (op > 0) check("b2b period", 32'($time - t_prev), 100);
            t_prev = $time;
            a8 = 8'h05; b8 = 8'h03;
            @(posedge clk); #1;
            check("b2b idle_gap", busy8, 0);
            if (op == 2) start8 = 1'b0;
        end

        // async reset mid-operation aborts without a done pulse
        run_op(1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, "pre_rst");
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", busy8, 0);
        check("abort done", done8, 0);
        check("abort diff", diff8, 0);
        check("abort borrow", borrow8, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        check("abort no_done", ndone, 0);
        run_op(1'b0, 8'h09, 8'h04, 8'h05, 1'b0, "post_rst");

        // exhaustive 4-bit sweep
        done4_cnt = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                m = model(4, 8'(ia), 8'(ib));
                run_op(1'b1, 8'(ia), 8'(ib), m[7:0], m[8], "w4");
            end
        end
        check("w4 done_count", done4_cnt, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
